// File: rtl/fp_align_stage_if.sv
// rtl/fp_align_stage_if.sv - operand/result handshake bundle for the alignment stage
interface fp_align_stage_if;
    logic [31:0] a;
    logic [31:0] b;
    logic        in_valid;
    logic        in_ready;
    logic [25:0] large_n;
    logic [25:0] small_n;
    logic        bit_r;
    logic [7:0]  e;
    logic        special;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output a, b, in_valid, out_ready,
        input  in_ready, large_n, small_n, bit_r, e, special, out_valid
    );

    modport slave (
        input  a, b, in_valid, out_ready,
        output in_ready, large_n, small_n, bit_r, e, special, out_valid
    );
endinterface

// File: rtl/fp_align_stage.sv
// rtl/fp_align_stage.sv - binary32 operand ordering, iterative alignment shift and sign application
module fp_align_stage #(
    parameter int SHIFT_STEP = 4
) (
    input  logic              clk,
    input  logic              rst,
    fp_align_stage_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMP   = 3'd1,
        SHIFT = 3'd2,
        NEG   = 3'd3,
        HOLD  = 3'd4
    } state_t;

    localparam logic [7:0] STEP8 = 8'(SHIFT_STEP);
    localparam logic [7:0] FAR_D = 8'd26;

    state_t state_q, state_d;

    logic [31:0] a_q, b_q;
    logic [24:0] m_large_q, m_small_q;
    logic        sign_large_q, sign_small_q;
    logic [7:0]  e_q;
    logic [7:0]  rem_q;
    logic        far_q;
    logic        sticky_q;

    logic [25:0] large_n_q, small_n_q;
    logic        bit_r_q;
    logic [7:0]  e_out_q;
    logic        special_q;

    // Unpacked view of the captured operands
    logic [7:0]  exp_a, exp_b, eff_a, eff_b;
    logic [24:0] m_a, m_b;
    logic        a_large;
    logic [7:0]  d;

    always_comb begin
        exp_a   = a_q[30:23];
        exp_b   = b_q[30:23];
        eff_a   = (exp_a == 8'd0) ? 8'd1 : exp_a;
        eff_b   = (exp_b == 8'd0) ? 8'd1 : exp_b;
        m_a     = {(exp_a != 8'd0), a_q[22:0], 1'b0};
        m_b     = {(exp_b != 8'd0), b_q[22:0], 1'b0};
        // On a full tie b wins, so a becomes the small operand
        a_large = (eff_a > eff_b) || ((eff_a == eff_b) && (m_a > m_b));
        d       = a_large ? (eff_a - eff_b) : (eff_b - eff_a);
    end

    logic [7:0]  step;
    logic [24:0] step_mask;

    always_comb begin
        step      = (rem_q < STEP8) ? rem_q : STEP8;
        step_mask = (25'd1 << step) - 25'd1;
    end

    function automatic logic [25:0] apply_sign(input logic s, input logic [24:0] m);
        logic [25:0] v;
        v = {1'b0, m};
        return s ? (~v + 26'd1) : v;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_d = CMP;
            CMP:     state_d = (d == 8'd0) ? NEG : SHIFT;
            SHIFT:   if (far_q || (rem_q <= STEP8)) state_d = NEG;
            NEG:     state_d = HOLD;
            HOLD:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q          <= '0;
            b_q          <= '0;
            m_large_q    <= '0;
            m_small_q    <= '0;
            sign_large_q <= 1'b0;
            sign_small_q <= 1'b0;
            e_q          <= '0;
            rem_q        <= '0;
            far_q        <= 1'b0;
            sticky_q     <= 1'b0;
            large_n_q    <= '0;
            small_n_q    <= '0;
            bit_r_q      <= 1'b0;
            e_out_q      <= '0;
            special_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q <= bus.a;
                        b_q <= bus.b;
                    end
                end
                CMP: begin
                    m_large_q    <= a_large ? m_a : m_b;
                    m_small_q    <= a_large ? m_b : m_a;
                    sign_large_q <= a_large ? a_q[31] : b_q[31];
                    sign_small_q <= a_large ? b_q[31] : a_q[31];
                    e_q          <= a_large ? eff_a : eff_b;
                    rem_q        <= d;
                    far_q        <= (d >= FAR_D);
                    sticky_q     <= 1'b0;
                end
                SHIFT: begin
                    // A distance of 26 or more clears the whole magnitude in one step
                    if (far_q) begin
                        m_small_q <= '0;
                        sticky_q  <= |m_small_q;
                        rem_q     <= '0;
                    end else begin
                        m_small_q <= m_small_q >> step;
                        sticky_q  <= sticky_q | (|(m_small_q & step_mask));
                        rem_q     <= rem_q - step;
                    end
                end
                NEG: begin
                    large_n_q <= apply_sign(sign_large_q, m_large_q);
                    small_n_q <= apply_sign(sign_small_q, m_small_q);
                    bit_r_q   <= sticky_q;
                    e_out_q   <= e_q;
                    special_q <= (a_q[30:23] == 8'hFF) || (b_q[30:23] == 8'hFF);
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = (state_q == HOLD);
    assign bus.large_n   = large_n_q;
    assign bus.small_n   = small_n_q;
    assign bus.bit_r     = bit_r_q;
    assign bus.e         = e_out_q;
    assign bus.special   = special_q;

endmodule
